// File: rtl/pacoblaze_io_ctrl_pkg.sv
// Shared constants for the PacoBlaze3 I/O and interrupt controller:
// the port_id address map and the interrupt FSM state encoding.
package pacoblaze_io_pkg;

  localparam logic [7:0] IN_BASE  = 8'h00;
  localparam logic [7:0] OUT_BASE = 8'h80;
  localparam logic [7:0] LCD_CTRL = 8'h20;
  localparam logic [7:0] LCD_DATA = 8'h40;
  localparam logic [7:0] IRQ_PEND = 8'hF0;
  localparam logic [7:0] IRQ_MASK = 8'hF1;
  localparam logic [7:0] IRQ_CLR  = 8'hF2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/pacoblaze_io_ctrl_if.sv
// CPU-side port bus of the PacoBlaze3: port address, strobes, data in
// both directions and the interrupt request/acknowledge pair.
interface pacoblaze_io_ctrl_if;
  import pacoblaze_io_pkg::*;

  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;

  // The CPU drives the address/strobes/write data and acknowledges.
  modport master (
    output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    input  in_port, interrupt
  );

  // The I/O controller decodes the bus and returns read data and requests.
  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    output in_port, interrupt
  );
endinterface

// File: rtl/pacoblaze_io_ctrl_irq.sv
// Edge-triggered interrupt controller: rising-edge detect into a pending
// register, a software mask, and a non-nesting IDLE/REQ/SERVICE FSM that
// produces the registered interrupt request.
module pacoblaze_irq_ctrl
  import pacoblaze_io_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               clr_we,
  input  logic [NUM_IRQ-1:0] clr_wdata,
  input  logic               interrupt_ack,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic               interrupt
);

  logic [NUM_IRQ-1:0] prev_reg;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] mask_reg;
  logic [NUM_IRQ-1:0] rise;
  logic               req_cond;
  irq_state_t         state_reg;
  logic               interrupt_reg;

  assign rise     = irq_src & ~prev_reg;
  assign req_cond = |(pending_reg & mask_reg);

  // Clear first, then OR in new edges so a same-cycle edge wins over W1C.
  always_comb begin
    pending_next = pending_reg;
    if (clr_we) begin
      pending_next = pending_next & ~clr_wdata;
    end
    pending_next = pending_next | rise;
  end

  // Edge history, pending latch (set even when masked) and the mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg    <= '0;
      pending_reg <= '0;
      mask_reg    <= '0;
    end else begin
      prev_reg    <= irq_src;
      pending_reg <= pending_next;
      if (mask_we) begin
        mask_reg <= mask_wdata;
      end
    end
  end

  // Request FSM; interrupt is registered and only high while in REQ.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      interrupt_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_cond) begin
            state_reg     <= REQ;
            interrupt_reg <= 1'b1;
          end
        end
        REQ: begin
          if (interrupt_ack) begin
            state_reg     <= SERVICE;
            interrupt_reg <= 1'b0;
          end else if (!req_cond) begin
            state_reg     <= IDLE;
            interrupt_reg <= 1'b0;
          end
        end
        SERVICE: begin
          // New edges keep latching in pending; the request is only
          // re-evaluated once software signals end-of-service.
          if (clr_we) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          interrupt_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pending   = pending_reg;
  assign mask      = mask_reg;
  assign interrupt = interrupt_reg;

endmodule

// File: rtl/pacoblaze_io_ctrl.sv
// PacoBlaze3 I/O controller top: exact port_id decode, output registers,
// registered input mux, LCD bus with synchronised read-back, and the
// interrupt controller sub-module.
module pacoblaze_io_ctrl
  import pacoblaze_io_pkg::*;
#(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 4,
  parameter int NUM_IRQ = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pacoblaze_io_ctrl_if.slave   bus,
  input  logic [NUM_IRQ-1:0]   irq_src,
  input  logic [NUM_IN*8-1:0]  in_data,
  output logic [NUM_OUT*8-1:0] out_data,
  inout  wire  [7:0]           lcd_d,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e
);

  logic               wr_lcd_ctrl;
  logic               wr_lcd_data;
  logic               wr_irq_mask;
  logic               wr_irq_clr;
  logic               lcd_rs_reg;
  logic               lcd_rw_reg;
  logic               lcd_e_reg;
  logic [7:0]         lcd_data_reg;
  logic [7:0]         lcd_sync1_reg;
  logic [7:0]         lcd_sync2_reg;
  logic [7:0]         rd_data;
  logic [7:0]         in_port_reg;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               irq_interrupt;
  logic               read_strobe_unused;

  // Reads have no side effects, so the read qualifier is not needed.
  assign read_strobe_unused = bus.read_strobe;

  assign wr_lcd_ctrl = bus.write_strobe && (bus.port_id == LCD_CTRL);
  assign wr_lcd_data = bus.write_strobe && (bus.port_id == LCD_DATA);
  assign wr_irq_mask = bus.write_strobe && (bus.port_id == IRQ_MASK);
  assign wr_irq_clr  = bus.write_strobe && (bus.port_id == IRQ_CLR);

  // One register per output port, each with its own exact address match.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
    logic [7:0] out_reg;

    // Output register gi loads on a strobed write to OUT_BASE+gi.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        out_reg <= '0;
      end else if (bus.write_strobe && (bus.port_id == OUT_BASE + 8'(gi))) begin
        out_reg <= bus.out_port;
      end
    end

    assign out_data[gi*8 +: 8] = out_reg;
  end

  // LCD control and data registers; rw resets to 1 so the bus starts released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_rs_reg   <= 1'b0;
      lcd_rw_reg   <= 1'b1;
      lcd_e_reg    <= 1'b0;
      lcd_data_reg <= '0;
    end else begin
      if (wr_lcd_ctrl) begin
        lcd_rs_reg <= bus.out_port[2];
        lcd_rw_reg <= bus.out_port[1];
        lcd_e_reg  <= bus.out_port[0];
      end
      if (wr_lcd_data) begin
        lcd_data_reg <= bus.out_port;
      end
    end
  end

  // Two-flop synchroniser for the externally driven LCD data pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_sync1_reg <= '0;
      lcd_sync2_reg <= '0;
    end else begin
      lcd_sync1_reg <= lcd_d;
      lcd_sync2_reg <= lcd_sync1_reg;
    end
  end

  assign lcd_d  = lcd_rw_reg ? 8'bzzzz_zzzz : lcd_data_reg;
  assign lcd_rs = lcd_rs_reg;
  assign lcd_rw = lcd_rw_reg;
  assign lcd_e  = lcd_e_reg;

  // Read mux over the full 8-bit address; anything unmapped reads 0x00.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.port_id == IN_BASE + 8'(i)) begin
        rd_data = in_data[i*8 +: 8];
      end
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      if (bus.port_id == OUT_BASE + 8'(j)) begin
        rd_data = out_data[j*8 +: 8];
      end
    end
    case (bus.port_id)
      LCD_CTRL: rd_data = {5'b0, lcd_rs_reg, lcd_rw_reg, lcd_e_reg};
      LCD_DATA: rd_data = lcd_sync2_reg;
      IRQ_PEND: rd_data = 8'(irq_pending);
      IRQ_MASK: rd_data = 8'(irq_mask);
      default:  ;
    endcase
  end

  // in_port follows port_id every cycle, one clock behind, like INPUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_port_reg <= '0;
    end else begin
      in_port_reg <= rd_data;
    end
  end

  assign bus.in_port   = in_port_reg;
  assign bus.interrupt = irq_interrupt;

  pacoblaze_irq_ctrl #(
    .NUM_IRQ (NUM_IRQ)
  ) u_irq (
    .clk           (clk),
    .reset_n       (reset_n),
    .irq_src       (irq_src),
    .mask_we       (wr_irq_mask),
    .mask_wdata    (bus.out_port[NUM_IRQ-1:0]),
    .clr_we        (wr_irq_clr),
    .clr_wdata     (bus.out_port[NUM_IRQ-1:0]),
    .interrupt_ack (bus.interrupt_ack),
    .pending       (irq_pending),
    .mask          (irq_mask),
    .interrupt     (irq_interrupt)
  );

endmodule

// File: tb/tb_pacoblaze_io_ctrl.sv
// Directed bench for pacoblaze_io_ctrl with default parameters (4/4/4).
module tb_pacoblaze_io_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  irq_src = 4'h0;
  logic [31:0] in_data = 32'h0;
  wire  [31:0] out_data;
  wire  [7:0]  lcd_d;
  wire         lcd_rs;
  wire         lcd_rw;
  wire         lcd_e;
  logic        tb_lcd_en = 1'b0;
  logic [7:0]  tb_lcd_val = 8'h00;
  int          checks = 0;
  int          failures = 0;

  pacoblaze_io_ctrl_if bus ();

  assign lcd_d = tb_lcd_en ? tb_lcd_val : 8'bzzzz_zzzz;

  pacoblaze_io_ctrl #(
    .NUM_IN  (4),
    .NUM_OUT (4),
    .NUM_IRQ (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .irq_src  (irq_src),
    .in_data  (in_data),
    .out_data (out_data),
    .lcd_d    (lcd_d),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    bus.port_id      = id;
    bus.out_port     = d;
    bus.write_strobe = 1'b1;
    step(1);
    bus.write_strobe = 1'b0;
    $display("write id=%h data=%h", id, d);
  endtask

  task automatic rd(input logic [7:0] id, output logic [7:0] d);
    bus.port_id = id;
    step(1);
    d = bus.in_port;
    $display("read  id=%h data=%h", id, d);
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=%h", out_data, 32'h0); end
    checks++; if (lcd_rw !== 1'b1) begin failures++; $display("FAIL reset_lcd_rw got=%b exp=1", lcd_rw); end
    checks++; if ({lcd_rs, lcd_e} !== 2'b00) begin failures++; $display("FAIL reset_lcd_rs_e got=%b exp=00", {lcd_rs, lcd_e}); end
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL reset_interrupt got=%b exp=0", bus.interrupt); end
    checks++; if (bus.in_port !== 8'h00) begin failures++; $display("FAIL reset_in_port got=%h exp=00", bus.in_port); end
    step(3);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_out_regs;
    logic [7:0] d;
    wr(8'h81, 8'h5A);
    checks++; if (out_data !== 32'h0000_5A00) begin failures++; $display("FAIL out_wr81 got=%h exp=%h", out_data, 32'h0000_5A00); end
    rd(8'h81, d);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL out_rd81 got=%h exp=5a", d); end
    bus.port_id = 8'h80; bus.out_port = 8'h77;
    step(1);
    checks++; if (out_data !== 32'h0000_5A00) begin failures++; $display("FAIL out_no_strobe got=%h exp=%h", out_data, 32'h0000_5A00); end
    wr(8'h84, 8'hFF);
    wr(8'h7F, 8'hFF);
    wr(8'hC1, 8'hFF);
    checks++; if (out_data !== 32'h0000_5A00) begin failures++; $display("FAIL out_unmapped got=%h exp=%h", out_data, 32'h0000_5A00); end
    wr(8'h83, 8'h11);
    checks++; if (out_data !== 32'h1100_5A00) begin failures++; $display("FAIL out_wr83 got=%h exp=%h", out_data, 32'h1100_5A00); end
    rd(8'h83, d);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL out_rd83 got=%h exp=11", d); end
  endtask

  task automatic test_input_mux;
    logic [7:0] d;
    in_data = 32'h44C3_2211;
    rd(8'h02, d);
    checks++; if (d !== 8'hC3) begin failures++; $display("FAIL in_port2 got=%h exp=c3", d); end
    rd(8'h03, d);
    checks++; if (d !== 8'h44) begin failures++; $display("FAIL in_port3 got=%h exp=44", d); end
    rd(8'h10, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL in_unmapped10 got=%h exp=00", d); end
    rd(8'h04, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL in_unmapped04 got=%h exp=00", d); end
    bus.port_id = 8'h01;
    #2;
    checks++; if (bus.in_port !== 8'h00) begin failures++; $display("FAIL in_latency got=%h exp=00", bus.in_port); end
    step(1);
    checks++; if (bus.in_port !== 8'h22) begin failures++; $display("FAIL in_port1 got=%h exp=22", bus.in_port); end
  endtask

  task automatic test_irq_edge;
    logic [7:0] d;
    wr(8'hF1, 8'hFF);
    rd(8'hF1, d);
    checks++; if (d !== 8'h0F) begin failures++; $display("FAIL irq_mask_upper got=%h exp=0f", d); end
    wr(8'hF1, 8'h01);
    irq_src = 4'h1;
    step(1);
    irq_src = 4'h0;
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL irq_edge_early got=%b exp=0", bus.interrupt); end
    step(1);
    checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL irq_edge_req got=%b exp=1", bus.interrupt); end
    bus.interrupt_ack = 1'b1;
    step(1);
    bus.interrupt_ack = 1'b0;
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL irq_ack_drop got=%b exp=0", bus.interrupt); end
    rd(8'hF0, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL irq_pend_01 got=%h exp=01", d); end
    wr(8'hF2, 8'h01);
    step(2);
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL irq_clr_norereq got=%b exp=0", bus.interrupt); end
    rd(8'hF0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL irq_pend_cleared got=%h exp=00", d); end
  endtask

  task automatic test_mask_nesting;
    logic [7:0] d;
    wr(8'hF1, 8'h00);
    irq_src = 4'h2;
    step(1);
    irq_src = 4'h0;
    step(2);
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL mask_blocks got=%b exp=0", bus.interrupt); end
    rd(8'hF0, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL mask_pend_02 got=%h exp=02", d); end
    wr(8'hF1, 8'h02);
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL mask_req_early got=%b exp=0", bus.interrupt); end
    step(1);
    checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL mask_req got=%b exp=1", bus.interrupt); end
    bus.interrupt_ack = 1'b1;
    step(1);
    bus.interrupt_ack = 1'b0;
    irq_src = 4'h1;
    step(1);
    irq_src = 4'h0;
    step(2);
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL nest_blocked got=%b exp=0", bus.interrupt); end
    rd(8'hF0, d);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL nest_pend_03 got=%h exp=03", d); end
    wr(8'hF2, 8'h02);
    step(2);
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL nest_src0_masked got=%b exp=0", bus.interrupt); end
    rd(8'hF0, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL nest_pend_01 got=%h exp=01", d); end
    wr(8'hF1, 8'h03);
    step(1);
    checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL nest_rereq got=%b exp=1", bus.interrupt); end
    bus.interrupt_ack = 1'b1;
    step(1);
    bus.interrupt_ack = 1'b0;
    wr(8'hF2, 8'h01);
    step(2);
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL nest_done got=%b exp=0", bus.interrupt); end
  endtask

  task automatic test_irq_drop;
    wr(8'hF1, 8'h01);
    irq_src = 4'h1;
    step(1);
    irq_src = 4'h0;
    step(1);
    checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL drop_req got=%b exp=1", bus.interrupt); end
    wr(8'hF1, 8'h00);
    step(1);
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL drop_masked got=%b exp=0", bus.interrupt); end
    bus.interrupt_ack = 1'b1;
    step(2);
    bus.interrupt_ack = 1'b0;
    wr(8'hF1, 8'h01);
    step(1);
    checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL ack_idle_ignored got=%b exp=1", bus.interrupt); end
    step(3);
    checks++; if (bus.interrupt !== 1'b1) begin failures++; $display("FAIL req_held got=%b exp=1", bus.interrupt); end
    bus.interrupt_ack = 1'b1;
    step(1);
    bus.interrupt_ack = 1'b0;
    wr(8'hF2, 8'h01);
    step(2);
    checks++; if (bus.interrupt !== 1'b0) begin failures++; $display("FAIL drop_done got=%b exp=0", bus.interrupt); end
  endtask

  task automatic test_collision;
    logic [7:0] d;
    wr(8'hF1, 8'h00);
    irq_src = 4'h4;
    wr(8'hF2, 8'h04);
    rd(8'hF0, d);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL coll_set_wins got=%h exp=04", d); end
    wr(8'hF2, 8'h04);
    step(10);
    rd(8'hF0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL coll_level_once got=%h exp=00", d); end
    irq_src = 4'h0;
    step(1);
    irq_src = 4'h4;
    step(1);
    rd(8'hF0, d);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL coll_new_edge got=%h exp=04", d); end
    irq_src = 4'h0;
    wr(8'hF2, 8'h04);
  endtask

  task automatic test_lcd;
    logic [7:0] d;
    wr(8'h20, 8'h00);
    wr(8'h40, 8'hA5);
    checks++; if (lcd_rw !== 1'b0) begin failures++; $display("FAIL lcd_rw_write got=%b exp=0", lcd_rw); end
    checks++; if (lcd_d !== 8'hA5) begin failures++; $display("FAIL lcd_drive got=%h exp=a5", lcd_d); end
    rd(8'h20, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL lcd_ctrl_rd0 got=%h exp=00", d); end
    wr(8'h20, 8'h05);
    checks++; if ({lcd_rs, lcd_rw, lcd_e} !== 3'b101) begin failures++; $display("FAIL lcd_ctrl_pins got=%b exp=101", {lcd_rs, lcd_rw, lcd_e}); end
    rd(8'h20, d);
    checks++; if (d !== 8'h05) begin failures++; $display("FAIL lcd_ctrl_rd5 got=%h exp=05", d); end
    step(2);
    rd(8'h40, d);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL lcd_readback_a5 got=%h exp=a5", d); end
    wr(8'h20, 8'h02);
    checks++; if ({lcd_rs, lcd_rw, lcd_e} !== 3'b010) begin failures++; $display("FAIL lcd_release got=%b exp=010", {lcd_rs, lcd_rw, lcd_e}); end
    tb_lcd_val = 8'h3C;
    tb_lcd_en  = 1'b1;
    bus.port_id = 8'h40;
    step(1);
    checks++; if (bus.in_port !== 8'hA5) begin failures++; $display("FAIL lcd_lag1 got=%h exp=a5", bus.in_port); end
    step(1);
    checks++; if (bus.in_port !== 8'hA5) begin failures++; $display("FAIL lcd_lag2 got=%h exp=a5", bus.in_port); end
    step(1);
    checks++; if (bus.in_port !== 8'h3C) begin failures++; $display("FAIL lcd_pin_3c got=%h exp=3c", bus.in_port); end
    tb_lcd_en = 1'b0;
    wr(8'h20, 8'h00);
    checks++; if (lcd_d !== 8'hA5) begin failures++; $display("FAIL lcd_redrive got=%h exp=a5", lcd_d); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    irq_src = 4'h2;
    step(1);
    irq_src = 4'h0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (lcd_rw !== 1'b1) begin failures++; $display("FAIL mid_lcd_rw got=%b exp=1", lcd_rw); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL mid_out_data got=%h exp=%h", out_data, 32'h0); end
    step(2);
    reset_n = 1'b1;
    step(1);
    rd(8'hF0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL mid_pend_lost got=%h exp=00", d); end
    wr(8'h20, 8'h00);
    checks++; if (lcd_d !== 8'h00) begin failures++; $display("FAIL mid_lcd_data got=%h exp=00", lcd_d); end
  endtask

  initial begin
    bus.port_id       = 8'h00;
    bus.write_strobe  = 1'b0;
    bus.read_strobe   = 1'b0;
    bus.out_port      = 8'h00;
    bus.interrupt_ack = 1'b0;
    test_reset();
    test_out_regs();
    test_input_mux();
    test_irq_edge();
    test_mask_nesting();
    test_irq_drop();
    test_collision();
    test_lcd();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pacoblaze_io_ctrl.md
Name: pacoblaze_io_ctrl

Overview:
Parametrised I/O and interrupt controller for the PacoBlaze3 soft core. Replaces hand-wired per-design port logic with:
- full 8-bit port_id decode
- N input ports, M output registers
- multi-source edge-triggered interrupt controller with mask, pending and in-service tracking
- 8-bit LCD bus with read-back

It sits between pacoblaze3 and board I/O (LEDs, audio/data inputs, LCD).

Parameters:
NUM_IN, 4, number of 8-bit input ports (1..16), port_id 0x00..NUM_IN-1
NUM_OUT, 4, number of 8-bit output registers (1..8), port_id 0x80..0x80+NUM_OUT-1
NUM_IRQ, 4, number of interrupt sources (1..8)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
port_id  input  8  CPU port address
write_strobe  input  1  CPU write qualifier
read_strobe  input  1  CPU read qualifier
out_port  input  8  CPU write data
in_port  output  8  CPU read data, registered
interrupt  output  1  interrupt request to CPU
interrupt_ack  input  1  CPU interrupt acknowledge
irq_src  input  NUM_IRQ  interrupt sources, synchronous to clk
in_data  input  NUM_IN*8  input port i = bits [8i+7:8i]
out_data  output  NUM_OUT*8  output register j = bits [8j+7:8j]
lcd_d  inout  8  LCD data bus
lcd_rs  output  1  LCD register select
lcd_rw  output  1  LCD read(1)/write(0)
lcd_e  output  1  LCD enable

Behaviour:
- Reset (async assert on reset_n low, sync release): all out_data, in_port, mask, pending, in_service and interrupt are 0; lcd_rs=0, lcd_e=0, lcd_rw=1 (bus tri-stated); lcd data register is 0.
- Address map (exact decode; no one-hot aliasing):
  - 0x00+i: read in_data port i
  - 0x80+j: read/write out_data j
  - 0x20: read/write LCD control {5'b0, rs, rw, e}
  - 0x40: write LCD data register; read returns synchronised lcd_d
  - 0xF0: read IRQ pending (zero-extended)
  - 0xF1: read/write IRQ mask
  - 0xF2: write-1-to-clear pending; any write to 0xF2 also clears in_service
- Writes:
  - Take effect on the clk edge where write_strobe=1.
  - Writes to unmapped ids are ignored.
  - Upper mask bits beyond NUM_IRQ are ignored and read 0.
- Reads:
  - in_port <= mux(port_id) every cycle regardless of read_strobe, giving one-cycle latency (matches the PacoBlaze INPUT timing).
  - Unmapped ids return 0x00. No read has side effects.
- LCD:
  - lcd_d is driven with the data register when lcd_rw=0, else high-Z.
  - Read-back passes through a 2-flop synchroniser, so the value seen at 0x40 lags the pin by 2 clk.
- IRQ edge detect:
  - prev <= irq_src each cycle.
  - A rising edge (irq_src & ~prev) sets pending[k].
  - A level held high produces exactly one set.
  - Edge and W1C on the same bit in the same cycle: set wins, bit stays 1.
  - Edges set pending even when masked.
- Interrupt FSM, states IDLE, REQ, SERVICE:
  - IDLE -> REQ when (pending & mask) != 0. interrupt=1 in REQ, registered, asserting one cycle after the qualifying condition.
  - REQ -> SERVICE on interrupt_ack; interrupt=0 from the next cycle.
  - REQ -> IDLE if the pending/mask condition drops before ack (e.g. software masks the source); interrupt drops next cycle.
  - SERVICE -> IDLE on any write to 0xF2.
  - New edges during SERVICE latch in pending and re-request only after return to IDLE (no nesting).
  - interrupt_ack outside REQ is ignored.
- Reset mid-operation: every state returns immediately to the reset values; pending edges are lost.

Decomposition:
- Package pacoblaze_io_pkg holds:
  - port address constants (IN_BASE=8'h00, OUT_BASE=8'h80, LCD_CTRL=8'h20, LCD_DATA=8'h40, IRQ_PEND=8'hF0, IRQ_MASK=8'hF1, IRQ_CLR=8'hF2)
  - the FSM state encoding
- One sub-module, pacoblaze_irq_ctrl (parameter NUM_IRQ), holds the edge detect, pending, mask, in-service FSM and interrupt output.
- Port decode, output registers, input mux and the LCD path stay in the top module.

Test Plan:
- Reset and I/O registers: with reset_n low, check out_data=0, lcd_rw=1, lcd_d=Z, interrupt=0. Release reset, write 0x5A to 0x81 -> out_data[15:8]=0x5A and other bytes 0. Set port_id=0x81 -> in_port=0x5A one cycle later.
- Input mux: in_data port2=0xC3, port_id=0x02 -> in_port=0xC3 after 1 clk. port_id=0x10 (unmapped for NUM_IN=4) -> in_port=0x00.
- Edge-triggered IRQ: mask=0x01, pulse irq_src[0] -> interrupt=1 within 2 clk. Assert ack -> interrupt=0 next cycle. Read 0xF0 -> 0x01. Write 0x01 to 0xF2 -> pending=0, FSM IDLE, no re-request.
- Masking and no-nesting: mask=0x00, edge on src1 -> pending=0x02, interrupt stays 0. Set mask=0x02 -> interrupt=1. After ack, raise src0 edge -> pending=0x03 but interrupt stays 0 until 0xF2 is written. Write 0x02 -> interrupt re-asserts only if mask covers src0.
- Set/clear collision: issue a W1C 0x04 in the same cycle as a src2 rising edge -> pending[2]=1. Hold src2 high for 10 clk -> only one set.
- LCD: write control 0x00 and data 0xA5 -> lcd_d=0xA5. Write control 0x02 -> lcd_d=Z. Drive the pin to 0x3C -> read 0x40 returns 0x3C no earlier than 2 clk later. Assert reset_n mid-transfer -> lcd_rw=1 immediately.
